// File: rtl/decode_stage_bt.sv
// RV32I decode stage with valid/ready handshakes and a free-list branch-tag allocator.
// Optional macro DEC_ILLEGAL_TRAP_EN adds out_illegal for unknown opcodes/func fields.
module decode_stage_bt #(
  parameter int BTAG_NUM = 4,
  parameter int BTAG_W   = $clog2(BTAG_NUM),
  parameter int OP_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [OP_W-1:0]     out_op,
  output logic [6:0]          out_class,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_imm,
  output logic [BTAG_NUM-1:0] out_btag_mask,
  output logic [BTAG_W-1:0]   out_btag,
  input  logic                free_en,
  input  logic [BTAG_W-1:0]   free_idx,
`ifdef DEC_ILLEGAL_TRAP_EN
  output logic                out_illegal,
`endif
  output logic [BTAG_NUM-1:0] tags_busy
);

  localparam logic [6:0] CLASS_NOP = 7'b0000000;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_RI    = 7'b0010011;
  localparam logic [6:0] OPC_RR    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(19);
  localparam logic [OP_W-1:0] OP_LUI = OP_W'(25);
  localparam logic [OP_W-1:0] OP_AUI = OP_W'(26);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(27);
  localparam logic [OP_W-1:0] OP_JLR = OP_W'(28);

  // ALU op order: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND -> 1..10
  function automatic logic [OP_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? OP_W'(2) : OP_W'(1);
      3'b001:  alu_op = OP_W'(3);
      3'b010:  alu_op = OP_W'(4);
      3'b011:  alu_op = OP_W'(5);
      3'b100:  alu_op = OP_W'(6);
      3'b101:  alu_op = alt ? OP_W'(8) : OP_W'(7);
      3'b110:  alu_op = OP_W'(9);
      default: alu_op = OP_W'(10);
    endcase
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_known, dec_legal, dec_branch;
  logic [OP_W-1:0] dec_op;
  logic [31:0] dec_imm;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec_known = 1'b1;
    dec_legal = 1'b1;
    dec_op    = OP_NOP;
    dec_imm   = 32'd0;
    case (opc)
      OPC_RR: begin
        dec_legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        dec_op    = alu_op(f3, in_inst[30]);
      end
      OPC_RI: begin
        dec_imm = imm_i;
        if (f3 == 3'b001)      dec_legal = (f7 == 7'b0);
        else if (f3 == 3'b101) dec_legal = (f7 == 7'b0) || (f7 == 7'b0100000);
        dec_op = alu_op(f3, (f3 == 3'b101) && in_inst[30]);
      end
      OPC_LD: begin
        dec_imm   = imm_i;
        dec_legal = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        dec_op    = (f3[2] ? OP_LB + OP_W'(3) : OP_LB) + OP_W'(f3[1:0]);
      end
      OPC_ST: begin
        dec_imm   = imm_s;
        dec_legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        dec_op    = OP_SB + OP_W'(f3[1:0]);
      end
      OPC_B: begin
        dec_imm   = imm_b;
        dec_legal = (f3[2:1] != 2'b01);
        dec_op    = f3[2] ? OP_BEQ + OP_W'(f3) - OP_W'(2) : OP_BEQ + OP_W'(f3);
      end
      OPC_LUI:   begin dec_imm = imm_u; dec_op = OP_LUI; end
      OPC_AUIPC: begin dec_imm = imm_u; dec_op = OP_AUI; end
      OPC_JAL:   begin dec_imm = imm_j; dec_op = OP_JAL; end
      OPC_JALR:  begin dec_imm = imm_i; dec_legal = (f3 == 3'b000); dec_op = OP_JLR; end
      default:   begin dec_known = 1'b0; dec_legal = 1'b0; end
    endcase
    if (!dec_legal) dec_op = OP_NOP;
  end

  assign dec_branch = dec_legal && (opc == OPC_B);

  logic [BTAG_NUM-1:0] busy_q, busy_d, free_vec, alloc_vec;
  logic [BTAG_W-1:0]   alloc_idx;
  logic                accept, alloc;
  logic                out_valid_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [OP_W-1:0]     op_q;
  logic [6:0]          class_q;
  logic [31:0]         pc_q, imm_q;
  logic [BTAG_NUM-1:0] mask_q;
  logic [BTAG_W-1:0]   btag_q;
  logic                illegal_q;

  // Allocation looks only at the registered busy mask, so a tag freed this cycle waits one cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = BTAG_NUM - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = BTAG_W'(i);
    end
  end

  assign in_ready = (~out_valid_q | out_ready) & ~flush & ~rst & ~(dec_branch & (&busy_q));
  assign accept   = in_valid & in_ready;
  assign alloc    = accept & dec_branch;

  for (genvar gi = 0; gi < BTAG_NUM; gi++) begin : g_tag
    assign free_vec[gi]  = free_en && (free_idx == BTAG_W'(gi));
    assign alloc_vec[gi] = alloc && (alloc_idx == BTAG_W'(gi));
  end

  assign busy_d = (busy_q & ~free_vec) | alloc_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0; out_valid_q <= 1'b0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      op_q <= OP_NOP; class_q <= CLASS_NOP; pc_q <= '0; imm_q <= '0;
      mask_q <= '0; btag_q <= '0; illegal_q <= 1'b0;
    end else if (flush) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        rs1_q       <= in_inst[19:15];
        rs2_q       <= in_inst[24:20];
        rd_q        <= in_inst[11:7];
        op_q        <= dec_op;
        class_q     <= dec_known ? opc : CLASS_NOP;
        pc_q        <= in_pc;
        imm_q       <= dec_known ? dec_imm : 32'd0;
        mask_q      <= busy_q & ~free_vec;
        btag_q      <= alloc ? alloc_idx : '0;
        illegal_q   <= ~dec_legal;
      end else begin
        if (out_ready) out_valid_q <= 1'b0;
        mask_q <= mask_q & ~free_vec;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_op        = op_q;
  assign out_class     = class_q;
  assign out_pc        = pc_q;
  assign out_imm       = imm_q;
  assign out_btag_mask = mask_q;
  assign out_btag      = btag_q;
  assign tags_busy     = busy_q;
`ifdef DEC_ILLEGAL_TRAP_EN
  assign out_illegal   = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule
